// File: rtl/mem_responder.sv
// Word-organised behavioural memory behind the MAR/MDR pair: accepts a held
// read or write request, waits LATENCY cycles, then completes with a one-cycle pulse.
module mem_responder #(
  parameter int DEPTH_BITS = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam int          Words   = 1 << DEPTH_BITS;
  localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;

  logic                    wr_q;
  logic [DEPTH_BITS-1:0]   idx_q;
  logic [15:0]             wdata_q;
  logic [1:0]              be_q;
  logic [15:0]             rdata_q;
  logic                    proto_q;

  logic [15:0]             mem_q [Words];

  logic                    req;
  logic                    accept;
  logic                    fire;
  logic                    fire_wr;
  logic [DEPTH_BITS-1:0]   fire_idx;
  logic [15:0]             fire_wdata;
  logic [1:0]              fire_be;
  logic                    unused_addr;

  assign req         = mem_read | mem_write;
  assign accept      = (state_q == IDLE) && req;
  assign unused_addr = ^mem_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // fire marks the edge entering RESP, where the array is read or written
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = LatInit;
          if (LATENCY == 1) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          fire    = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp  = (state_q == RESP);
    mem_rdata = rdata_q;
    proto_err = proto_q;
  end

  // With LATENCY=1 the completing edge is the accepting edge, so take live inputs
  always_comb begin
    if (state_q == IDLE) begin
      fire_wr    = mem_write;
      fire_idx   = mem_address[DEPTH_BITS:1];
      fire_wdata = mem_wdata;
      fire_be    = mem_byte_enable;
    end else begin
      fire_wr    = wr_q;
      fire_idx   = idx_q;
      fire_wdata = wdata_q;
      fire_be    = be_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      proto_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= mem_write;
        idx_q   <= mem_address[DEPTH_BITS:1];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        if (mem_read && mem_write) begin
          proto_q <= 1'b1;
        end
      end
      if (fire && !fire_wr) begin
        rdata_q <= mem_q[fire_idx];
      end
    end
  end

  // Array has no reset; the rst_n gate keeps a write from landing while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && fire && fire_wr) begin
      if (fire_be[0]) begin
        mem_q[fire_idx][7:0] <= fire_wdata[7:0];
      end
      if (fire_be[1]) begin
        mem_q[fire_idx][15:8] <= fire_wdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic against a word-array reference model, for LATENCY=3 and LATENCY=1.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        rd, wr;
  logic [1:0]  be;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        resp, perr;

  logic        rd1, wr1;
  logic [1:0]  be1;
  logic [15:0] addr1, wdata1;
  logic [15:0] rdata1;
  logic        resp1, perr1;

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] modelMem   [256];
  logic [1:0]  knownLanes [256];

  mem_responder #(.DEPTH_BITS(8), .LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(rd), .mem_write(wr), .mem_byte_enable(be),
    .mem_address(addr), .mem_wdata(wdata),
    .mem_rdata(rdata), .mem_resp(resp), .proto_err(perr)
  );

  mem_responder #(.DEPTH_BITS(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(rd1), .mem_write(wr1), .mem_byte_enable(be1),
    .mem_address(addr1), .mem_wdata(wdata1),
    .mem_rdata(rdata1), .mem_resp(resp1), .proto_err(perr1)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one request on the LATENCY=3 instance, scrambling inputs after acceptance
  task automatic txn(input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] b,
                     output int lat, output logic [15:0] rdOut);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    lat = 1;
    while (!resp && lat < 20) begin
      addr = 16'($urandom); wdata = 16'($urandom); be = 2'($urandom);
      @(negedge clk);
      lat++;
    end
    if (!resp) lat = 99;
    rdOut = rdata;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic txn1(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] b,
                      output int lat, output logic [15:0] rdOut);
    @(negedge clk);
    rd1 = r; wr1 = w; addr1 = a; wdata1 = d; be1 = b;
    @(negedge clk);
    lat = 1;
    while (!resp1 && lat < 20) begin
      addr1 = 16'($urandom); wdata1 = 16'($urandom); be1 = 2'($urandom);
      @(negedge clk);
      lat++;
    end
    if (!resp1) lat = 99;
    rdOut = rdata1;
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd = 0; wr = 0; be = 0; addr = 0; wdata = 0;
    rd1 = 0; wr1 = 0; be1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);
    nChecks++; if (resp !== 1'b0) $display("[TB] FAIL reset_resp: got %b expected 0", resp); else nPass++;
    nChecks++; if (rdata !== 16'h0000) $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata); else nPass++;
    nChecks++; if (perr !== 1'b0) $display("[TB] FAIL reset_proto: got %b expected 0", perr); else nPass++;
    nChecks++; if (resp1 !== 1'b0 || rdata1 !== 16'h0000) $display("[TB] FAIL reset_dut1: got %b/%h expected 0/0000", resp1, rdata1); else nPass++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] r;
    txn(0, 1, 16'h0040, 16'hBEEF, 2'b11, lat, r);
    nChecks++; if (lat != 3) $display("[TB] FAIL wr_latency: got %0d expected 3", lat); else nPass++;
    txn(1, 0, 16'h0040, 16'h0000, 2'b00, lat, r);
    nChecks++; if (lat != 3) $display("[TB] FAIL rd_latency: got %0d expected 3", lat); else nPass++;
    nChecks++; if (r !== 16'hBEEF) $display("[TB] FAIL rd_data: got %h expected BEEF", r); else nPass++;
    repeat (3) @(negedge clk);
    nChecks++; if (rdata !== 16'hBEEF) $display("[TB] FAIL rdata_hold: got %h expected BEEF", rdata); else nPass++;
    txn(0, 1, 16'h0042, 16'h1234, 2'b11, lat, r);
    nChecks++; if (rdata !== 16'hBEEF) $display("[TB] FAIL rdata_after_write: got %h expected BEEF", rdata); else nPass++;
  endtask

  task automatic test_byte_lanes();
    int lat; logic [15:0] r;
    txn(0, 1, 16'h0010, 16'h1234, 2'b11, lat, r);
    txn(0, 1, 16'h0010, 16'hAB00, 2'b10, lat, r);
    txn(1, 0, 16'h0010, 16'h0000, 2'b00, lat, r);
    nChecks++; if (r !== 16'hAB34) $display("[TB] FAIL lane_hi: got %h expected AB34", r); else nPass++;
    txn(0, 1, 16'h0010, 16'h00CD, 2'b01, lat, r);
    txn(1, 0, 16'h0010, 16'h0000, 2'b01, lat, r);
    nChecks++; if (r !== 16'hABCD) $display("[TB] FAIL lane_lo: got %h expected ABCD", r); else nPass++;
    txn(0, 1, 16'h0010, 16'hFFFF, 2'b00, lat, r);
    nChecks++; if (lat != 3) $display("[TB] FAIL lane_none_resp: got %0d expected 3", lat); else nPass++;
    txn(1, 0, 16'h0010, 16'h0000, 2'b10, lat, r);
    nChecks++; if (r !== 16'hABCD) $display("[TB] FAIL lane_none_data: got %h expected ABCD", r); else nPass++;
  endtask

  task automatic test_abort();
    int lat; logic [15:0] r; logic sawResp;
    txn(0, 1, 16'h0020, 16'h1111, 2'b11, lat, r);
    @(negedge clk);
    wr = 1; addr = 16'h0020; wdata = 16'h5555; be = 2'b11;
    @(negedge clk);
    wr = 0;
    sawResp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp) sawResp = 1'b1;
    end
    nChecks++; if (sawResp !== 1'b0) $display("[TB] FAIL abort_no_resp: got %b expected 0", sawResp); else nPass++;
    txn(1, 0, 16'h0020, 16'h0000, 2'b11, lat, r);
    nChecks++; if (r !== 16'h1111) $display("[TB] FAIL abort_data: got %h expected 1111", r); else nPass++;
  endtask

  task automatic test_protocol_error();
    int lat; logic [15:0] r;
    nChecks++; if (perr !== 1'b0) $display("[TB] FAIL proto_before: got %b expected 0", perr); else nPass++;
    txn(1, 1, 16'h0002, 16'h7777, 2'b11, lat, r);
    nChecks++; if (lat != 3) $display("[TB] FAIL proto_latency: got %0d expected 3", lat); else nPass++;
    nChecks++; if (perr !== 1'b1) $display("[TB] FAIL proto_set: got %b expected 1", perr); else nPass++;
    txn(1, 0, 16'h0002, 16'h0000, 2'b11, lat, r);
    nChecks++; if (r !== 16'h7777) $display("[TB] FAIL proto_write_done: got %h expected 7777", r); else nPass++;
    nChecks++; if (perr !== 1'b1) $display("[TB] FAIL proto_sticky: got %b expected 1", perr); else nPass++;
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic [15:0] r;
    txn(0, 1, 16'h0030, 16'h4242, 2'b11, lat, r);
    txn(1, 0, 16'h0030, 16'h0000, 2'b11, lat, r);
    nChecks++; if (r !== 16'h4242) $display("[TB] FAIL midrst_pre: got %h expected 4242", r); else nPass++;
    @(negedge clk);
    wr = 1; addr = 16'h0030; wdata = 16'hDEAD; be = 2'b11;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if (resp !== 1'b0) $display("[TB] FAIL midrst_resp: got %b expected 0", resp); else nPass++;
    nChecks++; if (rdata !== 16'h0000) $display("[TB] FAIL midrst_rdata: got %h expected 0000", rdata); else nPass++;
    nChecks++; if (perr !== 1'b0) $display("[TB] FAIL midrst_proto: got %b expected 0", perr); else nPass++;
    repeat (2) @(negedge clk);
    wr = 0;
    rst_n = 1'b1;
    txn(1, 0, 16'h0030, 16'h0000, 2'b11, lat, r);
    nChecks++; if (r !== 16'h4242) $display("[TB] FAIL midrst_discard: got %h expected 4242", r); else nPass++;
  endtask

  task automatic test_random();
    int lat, w;
    logic [15:0] r, a, d, mask, lastRead, lastMask;
    logic [7:0] idx;
    logic [1:0] b;
    logic isRead, haveLast;
    for (int i = 0; i < 256; i++) begin
      knownLanes[i] = 2'b00;
      modelMem[i] = 16'h0000;
    end
    haveLast = 1'b0; lastRead = '0; lastMask = '0;
    for (int n = 0; n < 40; n++) begin
      idx = 8'hA0 + 8'($urandom_range(0, 15));
      a = 16'(($urandom & 32'h0000FE00) | (32'(idx) << 1) | 32'($urandom_range(0, 1)));
      isRead = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      b = 2'($urandom_range(0, 3));
      txn(isRead, !isRead, a, d, b, lat, r);
      w = (int'(a) / 2) % 256;
      nChecks++; if (lat != 3) $display("[TB] FAIL rand_latency[%0d]: got %0d expected 3", n, lat); else nPass++;
      if (isRead) begin
        mask = {{8{knownLanes[w][1]}}, {8{knownLanes[w][0]}}};
        nChecks++;
        if ((r & mask) !== (modelMem[w] & mask))
          $display("[TB] FAIL rand_read[%0d]: got %h expected %h (mask %h)", n, r, modelMem[w], mask);
        else nPass++;
        lastRead = modelMem[w]; lastMask = mask; haveLast = 1'b1;
      end else begin
        if (b[0]) begin modelMem[w][7:0]  = d[7:0];  knownLanes[w][0] = 1'b1; end
        if (b[1]) begin modelMem[w][15:8] = d[15:8]; knownLanes[w][1] = 1'b1; end
        if (haveLast) begin
          nChecks++;
          if ((r & lastMask) !== (lastRead & lastMask))
            $display("[TB] FAIL rand_rdata_hold[%0d]: got %h expected %h", n, r, lastRead);
          else nPass++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t[3]; int cyc, n;
    t[0] = 0; t[1] = 0; t[2] = 0;
    @(negedge clk);
    rd = 1; addr = 16'h0040; be = 2'b11;
    cyc = 0; n = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (resp) begin
        t[n] = cyc;
        nChecks++; if (rdata !== 16'hBEEF) $display("[TB] FAIL b2b_data[%0d]: got %h expected BEEF", n, rdata); else nPass++;
        n++;
      end
    end
    rd = 0;
    nChecks++; if (n != 3) $display("[TB] FAIL b2b_count: got %0d expected 3", n); else nPass++;
    nChecks++; if (t[0] != 3) $display("[TB] FAIL b2b_first: got %0d expected 3", t[0]); else nPass++;
    nChecks++; if (t[1] - t[0] != 4) $display("[TB] FAIL b2b_gap1: got %0d expected 4", t[1] - t[0]); else nPass++;
    nChecks++; if (t[2] - t[1] != 4) $display("[TB] FAIL b2b_gap2: got %0d expected 4", t[2] - t[1]); else nPass++;
  endtask

  task automatic test_latency1();
    int lat; logic [15:0] r;
    txn1(0, 1, 16'h0202, 16'h9999, 2'b11, lat, r);
    nChecks++; if (lat != 1) $display("[TB] FAIL l1_wr_latency: got %0d expected 1", lat); else nPass++;
    txn1(1, 0, 16'h0002, 16'h0000, 2'b11, lat, r);
    nChecks++; if (lat != 1) $display("[TB] FAIL l1_rd_latency: got %0d expected 1", lat); else nPass++;
    nChecks++; if (r !== 16'h9999) $display("[TB] FAIL l1_wrap: got %h expected 9999", r); else nPass++;
    txn1(1, 0, 16'h0003, 16'h0000, 2'b00, lat, r);
    nChecks++; if (r !== 16'h9999) $display("[TB] FAIL l1_alias: got %h expected 9999", r); else nPass++;
    txn1(0, 1, 16'h0003, 16'h0055, 2'b01, lat, r);
    txn1(1, 0, 16'h0202, 16'h0000, 2'b11, lat, r);
    nChecks++; if (r !== 16'h9955) $display("[TB] FAIL l1_lane: got %h expected 9955", r); else nPass++;
  endtask

  // Scenario order matters: the sticky protocol flag is cleared by the mid-busy reset
  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_abort();
    test_protocol_error();
    test_reset_mid_busy();
    test_random();
    test_back_to_back();
    test_latency1();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-organised memory responder that serves the processor datapath's memory port: it accepts read and write requests carrying a 16-bit byte address and write data, waits a programmable number of cycles, and completes each request with a one-cycle response pulse. It sits on the far side of the memory address register (MAR) and memory data register (MDR): it consumes the MAR address and MDR write data, and drives the read data loaded back through the MDR mux. It serves as the behavioural main memory for simulation and as the backing store behind later cache work.

## Interface
- DEPTH_BITS, default 8: log2 of word count; the array holds 2^DEPTH_BITS 16-bit words.
- LATENCY, default 3: cycles from request acceptance to mem_resp. Legal range is 1..15.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset of control state and outputs. Array contents are not reset.
- mem_read  in  1  read request; held by the initiator until mem_resp.
- mem_write  in  1  write request; held by the initiator until mem_resp.
- mem_byte_enable  in  2  write lane enables: bit0 controls bits 7:0, bit1 controls bits 15:8.
- mem_address  in  16  byte address. Bit 0 is ignored. Word index is address[DEPTH_BITS:1].
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data; valid in the mem_resp cycle of a read.
- mem_resp  out  1  one-cycle completion pulse.
- proto_err  out  1  sticky flag, set when mem_read and mem_write are both high at acceptance.

## Operation
- FSM states are IDLE, BUSY and RESP. Reset state is IDLE.
- **IDLE**: if mem_read|mem_write is high at a rising edge, accept the request:
  - latch op, word index, wdata and byte enables;
  - load the counter with LATENCY-1;
  - go to RESP if LATENCY=1, else go to BUSY.
- **Both requests high at acceptance**: the request is treated as a write and proto_err is set. proto_err stays set until reset.
- **BUSY**: decrement the counter each edge.
  - When the counter reaches 1, go to RESP.
  - If mem_read|mem_write is low at any BUSY edge, abort: return to IDLE with no array update and no mem_resp.
- **RESP**: mem_resp=1 for exactly this cycle.
  - Read: mem_rdata = array[latched index], registered on the edge entering RESP.
  - Write: array lanes selected by the latched enables are updated on the edge entering RESP.
  - Next state is always IDLE.
- Inputs sampled only at acceptance. Changes to address, data or enables after acceptance are ignored.
- mem_byte_enable=00 on a write still completes with mem_resp but changes no data.
- Reads ignore mem_byte_enable and always return the full word.
- Address bits above DEPTH_BITS are ignored, so addresses wrap modulo 2^(DEPTH_BITS+1) bytes.
- mem_rdata holds its last read value after RESP. Writes do not change mem_rdata.

## Timing
- Reset values: mem_resp=0, mem_rdata=16'h0000, proto_err=0, state=IDLE, counter=0.
- Asserting rst_n low mid-transaction immediately forces IDLE and drops mem_resp. A pending write is discarded.
- With acceptance at edge E, mem_resp is high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after the request is first seen.
- After RESP there is one mandatory IDLE cycle:
  - the initiator drops its request in that cycle, so the next accept is at the earliest 2 edges after the RESP entry edge;
  - a request still held high in IDLE is accepted as a new transaction.
- Read-after-write to the same word: a read accepted after the write's RESP returns the new data.
- Back-to-back throughput is one transaction per LATENCY+1 cycles.

## Test plan
- **Reset:** assert rst_n=0 for 2 cycles mid-BUSY -> mem_resp=0, mem_rdata=0000 and proto_err=0 immediately. The aborted write address later reads back its old value.
- **Write/read, LATENCY=3:** write 16'hBEEF to 0x0040 with enables 11 -> mem_resp exactly 3 cycles after the request. A following read of 0x0040 returns BEEF with mem_resp 3 cycles after its request, and mem_rdata holds BEEF afterwards.
- **Byte lanes:**
  - word 0x0010 = 1234; write 16'hAB00 with enables 10 -> read returns AB34;
  - then write 16'h00CD with enables 01 -> read returns ABCD;
  - enables 00 -> still ABCD, and mem_resp still pulses.
- **Abort:** start a write of 5555 to 0x0020 (old value 1111) and drop mem_write after 1 cycle -> no mem_resp ever; a later read returns 1111.
- **Protocol error:** mem_read=mem_write=1 with wdata 7777 at 0x0002 -> proto_err=1 and stays 1. The write is performed, and a read of 0x0002 returns 7777.
- **Wrap and LATENCY=1** with DEPTH_BITS=8:
  - write 9999 to 0x0202, then read 0x0002 -> 9999;
  - 0x0003 aliases 0x0002;
  - mem_resp arrives in the cycle after acceptance.
